alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-side front end for the 4-bit combinational ALU core. Accepts {op,a,b} commands
//  over a valid/ready handshake, registers operands, drives the core's a/b/sel inputs and
//  captures the result into a one-entry response buffer returned over valid/ready.
//  Adds one multi-cycle op (MUL, shift-and-add through the core's ADD path).
//  Sits between the register-file/test controller and the ALU datapath.
// PARAMETERS
//  DATA_W   4   operand width; the core is 4-bit, so only 4 is supported
//  MUL_EN   1   1: opcode 4'b1001 executes MUL; 0: 4'b1001 decodes as illegal
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         sequencer can accept a command
//  cmd_op     in   4         opcode (table below)
//  cmd_a      in   DATA_W    operand A
//  cmd_b      in   DATA_W    operand B
//  resp_valid out  1         response buffer holds a result
//  resp_ready in   1         consumer takes the response
//  resp_data  out  2*DATA_W  result, zero-extended (MUL: full product)
//  resp_err   out  1         opcode was illegal
//  busy       out  1         state != IDLE
// BEHAVIOUR
//  Opcodes: 0 ADD {c,sum}, 1 SUB {borrow,diff} (bit4=1 iff a<b), 2 AND, 3 OR, 4 XOR, 5 XNOR,
//   6 NOT a, 7 a>>b, 8 a<<b (b>=4 gives 0), 9 MUL a*b (8-bit), 10-15 illegal.
//  ADD/SUB return 5 significant bits; logic and shift ops return 4 bits; upper bits are 0.
//  Reset (async, rst_n=0): state=IDLE, cmd_ready=0 while rst_n low, resp_valid=0,
//   resp_data=0, resp_err=0, busy=0, and operand/accumulator registers =0.
//   An operation in progress is abandoned and its response is never issued.
//  FSM IDLE -> EXEC | MUL -> RESP -> IDLE:
//   IDLE: cmd_ready=1. Handshake (cmd_valid&cmd_ready) latches op/a/b. Next state is
//    MUL for op 9 with MUL_EN=1, otherwise EXEC. Illegal opcodes go to EXEC.
//   EXEC: one cycle. Core driven from the latched registers. At the clock edge the result
//    is written to resp_data, resp_err is set (illegal op: resp_data=0, resp_err=1), and the
//    next state is RESP.
//   MUL: exactly 4 cycles, one per multiplier bit (LSB first), iteration count i=0..3.
//    If b[i]=1, acc += a<<i. After i=3: resp_data=acc and the next state is RESP.
//   RESP: resp_valid=1. resp_data and resp_err stay stable until resp_ready=1, then the
//    next state is IDLE. cmd_ready=0 in RESP, so there is no accept in the same cycle.
//  Latency, counted from the accept edge: EXEC ops give resp_valid=1 after 2 edges;
//   MUL gives resp_valid=1 after 5 edges. Throughput is at best one op per 3 cycles.
//  cmd_* inputs are ignored outside IDLE. Back-pressure on resp_ready stalls indefinitely
//   with no data loss. resp_valid never drops without resp_ready.
//  The core's undriven/'z' default is never exposed: illegal ops are caught before the core.
//  cmd_ready is registered/state-decoded. There is no combinational path from cmd_valid
//   or resp_ready to any output.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_ADD..OP_MUL), state enum
//   {IDLE,EXEC,MUL,RESP}, DATA_W.
//  Sub-module alu4_core: combinational a/b/sel -> {flag,y}, with the op encoding above.
//   The sequencer instantiates it once. MUL reuses its ADD via an 8-bit accumulator
//   adder local to the sequencer.
// TESTING
//  1. ADD a=9,b=8, resp_ready=1 -> resp_valid 2 edges after accept, resp_data=8'h11,
//     resp_err=0.
//  2. SUB a=3,b=5 -> resp_data=8'h1E (borrow=1, diff=4'hE). SHL a=4'h3,b=5 -> 8'h00.
//  3. MUL a=15,b=15 -> busy for 5 edges, resp_data=8'hE1. MUL a=0,b=7 -> 8'h00.
//  4. Illegal op 4'hC -> resp_err=1, resp_data=0. With MUL_EN=0, op 9 -> resp_err=1.
//  5. Hold resp_ready=0 for 10 cycles while cmd_valid is toggled -> resp_data stable,
//     cmd_ready=0, no extra accept. Raising resp_ready -> IDLE next cycle.
//  6. Assert rst_n=0 mid-MUL (i=2) -> all outputs 0 immediately. After release, a new
//     ADD 1+1 returns 8'h02 and no stale response appears.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer and its 4-bit core.
//   DATA_W        operand width of the core (fixed at 4)
//   OP_*          opcode encodings; values above OP_MUL are illegal
//   state_t       sequencer FSM states
//   is_core_op()  true for opcodes the combinational core evaluates in one pass
package alu_pkg;

    localparam int unsigned DATA_W = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RESP
    } state_t;

    function automatic logic is_core_op(input logic [3:0] op);
        return op <= OP_SHL;
    endfunction

endpackage

// File: rtl/alu4_core.sv
// Combinational 4-bit ALU core.
//   a, b  operands
//   sel   opcode (OP_ADD..OP_SHL); any other value yields 0
//   y     4-bit result
//   flag  carry for ADD, borrow (a<b) for SUB, 0 otherwise
module alu4_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        sel,
    output logic [DATA_W-1:0] y,
    output logic              flag
);

    always_comb begin
        y    = '0;
        flag = 1'b0;
        unique case (sel)
            OP_ADD:  {flag, y} = {1'b0, a} + {1'b0, b};
            // Bit 4 of the 5-bit difference is the borrow, i.e. a < b.
            OP_SUB:  {flag, y} = {1'b0, a} - {1'b0, b};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_SHR:  y = a >> b;
            // Shift amounts of 4 or more push every bit out, giving 0.
            OP_SHL:  y = a << b;
            default: begin
                y    = '0;
                flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side front end for the 4-bit ALU core.
// Accepts {op,a,b} over valid/ready, evaluates single-pass ops through alu4_core,
// runs MUL as a 4-step shift-and-add, and returns the result from a one-entry
// response buffer over valid/ready.
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_op/cmd_a/cmd_b payload
//   resp_valid/resp_ready  response handshake; resp_data/resp_err payload
//   busy                   FSM is not idle
module alu_cmd_sequencer #(
    parameter int unsigned DATA_W = 4,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd_op,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [2*DATA_W-1:0] resp_data,
    output logic                resp_err,
    output logic                busy
);
    import alu_pkg::*;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [2*DATA_W-1:0] resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                ready_q, ready_d;

    logic [3:0]          core_sel;
    logic [DATA_W-1:0]   core_y;
    logic                core_flag;
    logic                core_legal;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] partial;
    logic [2*DATA_W-1:0] acc_sum;

    // Illegal opcodes never reach the core; it sees a harmless ADD instead.
    assign core_legal = is_core_op(op_q);
    assign core_sel   = core_legal ? op_q : OP_ADD;

    alu4_core u_core (
        .a    (a_q),
        .b    (b_q),
        .sel  (core_sel),
        .y    (core_y),
        .flag (core_flag)
    );

    // Shift-and-add step for multiplier bit cnt_q.
    assign a_ext   = {{DATA_W{1'b0}}, a_q};
    assign partial = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    assign acc_sum = acc_q + partial;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d  = cmd_op;
                    a_d   = cmd_a;
                    b_d   = cmd_b;
                    acc_d = '0;
                    cnt_d = '0;
                    state_d = ((cmd_op == OP_MUL) && MUL_EN) ? MUL : EXEC;
                end
            end
            EXEC: begin
                if (core_legal) begin
                    resp_data_d = {{(DATA_W-1){1'b0}}, core_flag, core_y};
                    resp_err_d  = 1'b0;
                end else begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
                state_d = RESP;
            end
            MUL: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    resp_data_d = acc_sum;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered ready keeps cmd_ready low during reset and free of input paths.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign resp_valid = (state_q == RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed corner cases plus random
// commands compared against an arithmetic reference model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       busy;

    // Second instance with MUL disabled.
    logic       c2_valid = 1'b0;
    logic       c2_ready;
    logic [3:0] c2_op = '0;
    logic [3:0] c2_a = '0;
    logic [3:0] c2_b = '0;
    logic       r2_valid;
    logic       r2_ready = 1'b0;
    logic [7:0] r2_data;
    logic       r2_err;
    logic       busy2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DATA_W(4), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    alu_cmd_sequencer #(.DATA_W(4), .MUL_EN(1'b0)) dut_nomul (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (c2_valid),
        .cmd_ready  (c2_ready),
        .cmd_op     (c2_op),
        .cmd_a      (c2_a),
        .cmd_b      (c2_b),
        .resp_valid (r2_valid),
        .resp_ready (r2_ready),
        .resp_data  (r2_data),
        .resp_err   (r2_err),
        .busy       (busy2)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result as defined by the opcode table, in plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b, input bit mul_en,
                                  output logic [7:0] d, output logic e);
        int r;
        r = 0;
        e = 1'b0;
        case (op)
            0: r = a + b;
            1: r = ((a - b) & 15) + ((a < b) ? 16 : 0);
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (~(a ^ b)) & 15;
            6: r = (~a) & 15;
            7: r = a >> b;
            8: r = (b >= 4) ? 0 : ((a << b) & 15);
            9: if (mul_en) r = a * b; else e = 1'b1;
            default: e = 1'b1;
        endcase
        d = 8'(r);
    endfunction

    // Issue one command, check latency and payload, hold back-pressure, then drain.
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input int hold, input bit toggle, input string tag);
        logic [7:0] ed;
        logic       ee;
        int n;
        int lat;
        model(int'(op), int'(a), int'(b), 1'b1, ed, ee);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(32'(cmd_ready), 32'd1, {tag, "/ready"});
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        chk(32'(cmd_ready), 32'd0, {tag, "/ready_after_accept"});
        chk(32'(busy), 32'd1, {tag, "/busy"});
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(32'(lat), (op == 4'd9) ? 32'd5 : 32'd2, {tag, "/latency"});
        chk(32'(resp_data), 32'(ed), {tag, "/data"});
        chk(32'(resp_err), 32'(ee), {tag, "/err"});
        for (int k = 0; k < hold; k++) begin
            if (toggle) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 4'($urandom);
                cmd_a     = 4'($urandom);
                cmd_b     = 4'($urandom);
            end
            @(posedge clk); #1;
            chk(32'(resp_valid), 32'd1, {tag, "/hold_valid"});
            chk(32'(resp_data), 32'(ed), {tag, "/hold_data"});
            chk(32'(cmd_ready), 32'd0, {tag, "/hold_ready"});
        end
        cmd_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk(32'(resp_valid), 32'd0, {tag, "/drained"});
        chk(32'(busy), 32'd0, {tag, "/idle"});
    endtask

    initial begin
        logic [7:0] ed;
        logic       ee;
        int n;

        // Reset state while rst_n is held low.
        #12;
        chk(32'(cmd_ready), 32'd0, "rst/ready");
        chk(32'(resp_valid), 32'd0, "rst/valid");
        chk(32'(resp_data), 32'd0, "rst/data");
        chk(32'(resp_err), 32'd0, "rst/err");
        chk(32'(busy), 32'd0, "rst/busy");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases.
        do_cmd(4'd0, 4'd9, 4'd8, 0, 1'b0, "add_9_8");
        do_cmd(4'd1, 4'd3, 4'd5, 1, 1'b0, "sub_3_5");
        do_cmd(4'd8, 4'd3, 4'd5, 0, 1'b0, "shl_b5");
        do_cmd(4'd8, 4'd3, 4'd3, 0, 1'b0, "shl_b3");
        do_cmd(4'd7, 4'hF, 4'd2, 0, 1'b0, "shr");
        do_cmd(4'd9, 4'd15, 4'd15, 0, 1'b0, "mul_15_15");
        do_cmd(4'd9, 4'd0, 4'd7, 0, 1'b0, "mul_0_7");
        do_cmd(4'hC, 4'd5, 4'd6, 0, 1'b0, "illegal_c");
        do_cmd(4'd5, 4'hA, 4'h6, 10, 1'b1, "backpressure");
        // No stray accept from the toggled cmd_valid.
        @(posedge clk); #1;
        chk(32'(busy), 32'd0, "backpressure/no_extra_accept");

        // MUL disabled: opcode 9 is illegal and takes the single-pass path.
        model(9, 3, 5, 1'b0, ed, ee);
        n = 0;
        while (c2_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        c2_valid = 1'b1;
        c2_op    = 4'd9;
        c2_a     = 4'd3;
        c2_b     = 4'd5;
        @(posedge clk); #1;
        c2_valid = 1'b0;
        n = 1;
        while (r2_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(32'(n), 32'd2, "nomul/latency");
        chk(32'(r2_err), 32'(ee), "nomul/err");
        chk(32'(r2_data), 32'(ed), "nomul/data");
        r2_ready = 1'b1;
        @(posedge clk); #1;
        r2_ready = 1'b0;
        chk(32'(busy2), 32'd0, "nomul/idle");

        // Random commands against the model.
        for (int t = 0; t < 24; t++) begin
            do_cmd(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
        end

        // Reset in the middle of a MUL (iteration 2).
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = 4'd9;
        cmd_a     = 4'd15;
        cmd_b     = 4'd15;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk(32'(busy), 32'd1, "midmul/busy_before");
        rst_n = 1'b0;
        #1;
        chk(32'(cmd_ready), 32'd0, "midmul/ready");
        chk(32'(resp_valid), 32'd0, "midmul/valid");
        chk(32'(resp_data), 32'd0, "midmul/data");
        chk(32'(resp_err), 32'd0, "midmul/err");
        chk(32'(busy), 32'd0, "midmul/busy");
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk(32'(resp_valid), 32'd0, "midmul/no_stale_resp");
        end
        resp_ready = 1'b0;
        do_cmd(4'd0, 4'd1, 4'd1, 0, 1'b0, "post_reset_add");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
